// File: rtl/chip8_mem_arbiter_if.sv
// Bus bundle between the three CHIP-8 memory requesters, the arbiter and
// the synchronous-read main memory macro.
interface chip8_mem_arbiter_if #(
    parameter int AW = 12,
    parameter int DW = 8
);
    logic          f_req;
    logic [AW-1:0] f_addr;
    logic          f_gnt;
    logic          f_rvalid;

    logic          d_req;
    logic          d_we;
    logic          d_lock;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;

    logic          v_req;
    logic [AW-1:0] v_addr;
    logic          v_gnt;
    logic          v_rvalid;

    logic [DW-1:0] rdata;
    logic          locked;
    logic          lock_err;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    // Requesters and memory model side
    modport master (
        output f_req, f_addr,
        output d_req, d_we, d_lock, d_addr, d_wdata,
        output v_req, v_addr,
        output mem_rdata,
        input  f_gnt, f_rvalid, d_gnt, d_rvalid, v_gnt, v_rvalid,
        input  rdata, locked, lock_err,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

    // Arbiter side
    modport slave (
        input  f_req, f_addr,
        input  d_req, d_we, d_lock, d_addr, d_wdata,
        input  v_req, v_addr,
        input  mem_rdata,
        output f_gnt, f_rvalid, d_gnt, d_rvalid, v_gnt, v_rvalid,
        output rdata, locked, lock_err,
        output mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/chip8_mem_arbiter.sv
// Rotating-priority arbiter for the CHIP-8 4 KiB main memory, shared by
// instruction fetch (F), CPU data access (D) and the sprite reader (V).
// The data port may lock the memory for multi-byte transfers; a lock that
// reaches LOCK_MAX beats is released by force and flagged on lock_err.
//
//   state     | meaning
//   ----------+-------------------------------------------------------
//   ST_IDLE   | arbitrate F/D/V by rotating priority starting at ptr
//   ST_LOCKED | only D may be granted; ptr frozen; beats are counted
module chip8_mem_arbiter #(
    parameter int AW       = 12,
    parameter int DW       = 8,
    parameter int LOCK_MAX = 16
) (
    input logic               clk,
    input logic               rst,
    chip8_mem_arbiter_if.slave bus
);
    localparam int CW = $clog2(LOCK_MAX + 1);
    localparam logic [CW-1:0] BEAT_MAX = CW'(LOCK_MAX);

    typedef enum logic {ST_IDLE, ST_LOCKED} state_t;
    typedef enum logic [1:0] {SEL_F, SEL_D, SEL_V} sel_t;

    state_t        state, state_nxt;
    sel_t          ptr, ptr_nxt;
    logic [CW-1:0] beat_cnt, beat_nxt, beat_inc;
    logic          gnt_f, gnt_d, gnt_v;
    logic          lock_err_c;
    logic          f_rv_q, d_rv_q, v_rv_q;

    assign beat_inc = beat_cnt + CW'(1);

    // Grant selection, memory drive and next-state decode
    always_comb begin
        gnt_f      = 1'b0;
        gnt_d      = 1'b0;
        gnt_v      = 1'b0;
        lock_err_c = 1'b0;
        state_nxt  = state;
        ptr_nxt    = ptr;
        beat_nxt   = beat_cnt;

        if (!rst) begin
            if (state == ST_LOCKED) begin
                gnt_d = bus.d_req;
            end else begin
                case (ptr)
                    SEL_F: begin
                        if (bus.f_req)      gnt_f = 1'b1;
                        else if (bus.d_req) gnt_d = 1'b1;
                        else if (bus.v_req) gnt_v = 1'b1;
                    end
                    SEL_D: begin
                        if (bus.d_req)      gnt_d = 1'b1;
                        else if (bus.v_req) gnt_v = 1'b1;
                        else if (bus.f_req) gnt_f = 1'b1;
                    end
                    default: begin
                        if (bus.v_req)      gnt_v = 1'b1;
                        else if (bus.f_req) gnt_f = 1'b1;
                        else if (bus.d_req) gnt_d = 1'b1;
                    end
                endcase
            end
        end

        case (state)
            ST_IDLE: begin
                if (gnt_f) ptr_nxt = SEL_D;
                if (gnt_v) ptr_nxt = SEL_F;
                if (gnt_d) begin
                    ptr_nxt = SEL_V;
                    if (bus.d_lock) begin
                        state_nxt = ST_LOCKED;
                        beat_nxt  = CW'(1);
                    end
                end
            end
            default: begin
                if (gnt_d) begin
                    if (!bus.d_lock || beat_inc == BEAT_MAX) begin
                        // Normal release or forced release at the beat limit
                        state_nxt  = ST_IDLE;
                        ptr_nxt    = SEL_V;
                        beat_nxt   = '0;
                        lock_err_c = bus.d_lock;
                    end else begin
                        beat_nxt = beat_inc;
                    end
                end
            end
        endcase
    end

    // State, priority pointer, beat counter and read-valid strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            ptr      <= SEL_F;
            beat_cnt <= '0;
            f_rv_q   <= 1'b0;
            d_rv_q   <= 1'b0;
            v_rv_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            beat_cnt <= beat_nxt;
            f_rv_q   <= gnt_f;
            d_rv_q   <= gnt_d & ~bus.d_we;
            v_rv_q   <= gnt_v;
        end
    end

    assign bus.f_gnt     = gnt_f;
    assign bus.d_gnt     = gnt_d;
    assign bus.v_gnt     = gnt_v;
    assign bus.f_rvalid  = f_rv_q;
    assign bus.d_rvalid  = d_rv_q;
    assign bus.v_rvalid  = v_rv_q;
    assign bus.rdata     = bus.mem_rdata;
    assign bus.locked    = (state == ST_LOCKED);
    assign bus.lock_err  = lock_err_c;
    assign bus.mem_en    = gnt_f | gnt_d | gnt_v;
    assign bus.mem_we    = gnt_d & bus.d_we;
    assign bus.mem_addr  = gnt_d ? bus.d_addr : (gnt_v ? bus.v_addr : bus.f_addr);
    assign bus.mem_wdata = bus.d_wdata;
endmodule

// File: tb/tb_chip8_mem_arbiter.sv
// Directed bench for chip8_mem_arbiter: one table of per-cycle vectors plus
// hand-written sequences for the forced lock release and reset mid-lock.
module tb_chip8_mem_arbiter;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    chip8_mem_arbiter_if #(.AW(12), .DW(8)) bus ();

    chip8_mem_arbiter #(.AW(12), .DW(8), .LOCK_MAX(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic        r;
        logic [2:0]  req;   // {f, d, v}
        logic        we;
        logic        lk;
        logic [11:0] fa;
        logic [11:0] da;
        logic [11:0] va;
        logic [7:0]  wd;
        logic [7:0]  rd;
        logic [2:0]  eg;    // expected {f_gnt, d_gnt, v_gnt}
        logic [2:0]  erv;   // expected {f_rvalid, d_rvalid, v_rvalid}
        logic        ewe;
        logic [11:0] ea;
        logic        elk;
        logic        eerr;
    } vec_t;

    vec_t tbl[22];

    function automatic vec_t mk(string nm, logic r, logic [2:0] req, logic we, logic lk,
                                logic [11:0] fa, logic [11:0] da, logic [11:0] va,
                                logic [7:0] wd, logic [7:0] rd,
                                logic [2:0] eg, logic [2:0] erv, logic ewe,
                                logic [11:0] ea, logic elk, logic eerr);
        vec_t t;
        t.nm = nm; t.r = r; t.req = req; t.we = we; t.lk = lk;
        t.fa = fa; t.da = da; t.va = va; t.wd = wd; t.rd = rd;
        t.eg = eg; t.erv = erv; t.ewe = ewe; t.ea = ea; t.elk = elk; t.eerr = eerr;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_outs(input vec_t t);
        chk({t.nm, ".gnt"}, {29'd0, bus.f_gnt, bus.d_gnt, bus.v_gnt}, {29'd0, t.eg});
        chk({t.nm, ".rvalid"}, {29'd0, bus.f_rvalid, bus.d_rvalid, bus.v_rvalid}, {29'd0, t.erv});
        chk({t.nm, ".mem_en"}, {31'd0, bus.mem_en}, {31'd0, (t.eg != 3'b000)});
        chk({t.nm, ".mem_we"}, {31'd0, bus.mem_we}, {31'd0, t.ewe});
        if (t.eg != 3'b000)
            chk({t.nm, ".mem_addr"}, {20'd0, bus.mem_addr}, {20'd0, t.ea});
        chk({t.nm, ".mem_wdata"}, {24'd0, bus.mem_wdata}, {24'd0, t.wd});
        chk({t.nm, ".rdata"}, {24'd0, bus.rdata}, {24'd0, t.rd});
        chk({t.nm, ".locked"}, {31'd0, bus.locked}, {31'd0, t.elk});
        chk({t.nm, ".lock_err"}, {31'd0, bus.lock_err}, {31'd0, t.eerr});
    endtask

    task automatic drive(input vec_t t);
        rst           = t.r;
        bus.f_req     = t.req[2];
        bus.d_req     = t.req[1];
        bus.v_req     = t.req[0];
        bus.d_we      = t.we;
        bus.d_lock    = t.lk;
        bus.f_addr    = t.fa;
        bus.d_addr    = t.da;
        bus.v_addr    = t.va;
        bus.d_wdata   = t.wd;
        bus.mem_rdata = t.rd;
    endtask

    task automatic step(input vec_t t);
        @(negedge clk);
        drive(t);
        #1;
        check_outs(t);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        bus.f_req = 1'b0; bus.d_req = 1'b0; bus.v_req = 1'b0;
        bus.d_we = 1'b0; bus.d_lock = 1'b0;
        bus.f_addr = '0; bus.d_addr = '0; bus.v_addr = '0;
        bus.d_wdata = '0; bus.mem_rdata = '0;

        //              name            r  req     we lk fa      da      va      wd     rd     eg      erv     we ea     lk err
        tbl[0]  = mk("rst_all",       1, 3'b111, 0, 0, 12'h200, 12'h300, 12'h400, 8'h00, 8'h11, 3'b000, 3'b000, 0, 12'h000, 0, 0);
        tbl[1]  = mk("rst_idle",      1, 3'b000, 0, 0, 12'h200, 12'h300, 12'h400, 8'h00, 8'h11, 3'b000, 3'b000, 0, 12'h000, 0, 0);
        tbl[2]  = mk("fetch",         0, 3'b100, 0, 0, 12'h200, 12'h300, 12'h400, 8'h00, 8'h12, 3'b100, 3'b000, 0, 12'h200, 0, 0);
        tbl[3]  = mk("fetch_rv",      0, 3'b000, 0, 0, 12'h200, 12'h300, 12'h400, 8'h00, 8'h12, 3'b000, 3'b100, 0, 12'h000, 0, 0);
        tbl[4]  = mk("rst_again",     1, 3'b000, 0, 0, 12'h200, 12'h300, 12'h400, 8'h00, 8'h13, 3'b000, 3'b000, 0, 12'h000, 0, 0);
        tbl[5]  = mk("rot_f",         0, 3'b111, 0, 0, 12'h210, 12'h310, 12'h410, 8'h00, 8'h21, 3'b100, 3'b000, 0, 12'h210, 0, 0);
        tbl[6]  = mk("rot_d",         0, 3'b111, 0, 0, 12'h210, 12'h310, 12'h410, 8'h00, 8'h22, 3'b010, 3'b100, 0, 12'h310, 0, 0);
        tbl[7]  = mk("rot_v",         0, 3'b111, 0, 0, 12'h210, 12'h310, 12'h410, 8'h00, 8'h23, 3'b001, 3'b010, 0, 12'h410, 0, 0);
        tbl[8]  = mk("rot_f2",        0, 3'b111, 0, 0, 12'h210, 12'h310, 12'h410, 8'h00, 8'h24, 3'b100, 3'b001, 0, 12'h210, 0, 0);
        tbl[9]  = mk("rot_d2",        0, 3'b111, 0, 0, 12'h210, 12'h310, 12'h410, 8'h00, 8'h25, 3'b010, 3'b100, 0, 12'h310, 0, 0);
        tbl[10] = mk("rot_v2",        0, 3'b111, 0, 0, 12'h210, 12'h310, 12'h410, 8'h00, 8'h26, 3'b001, 3'b010, 0, 12'h410, 0, 0);
        tbl[11] = mk("rot_tail",      0, 3'b000, 0, 0, 12'h210, 12'h310, 12'h410, 8'h00, 8'h27, 3'b000, 3'b001, 0, 12'h000, 0, 0);
        tbl[12] = mk("d_write",       0, 3'b010, 1, 0, 12'h200, 12'h300, 12'h400, 8'hA5, 8'h30, 3'b010, 3'b000, 1, 12'h300, 0, 0);
        tbl[13] = mk("d_write_norv",  0, 3'b000, 0, 0, 12'h200, 12'h300, 12'h400, 8'h00, 8'h31, 3'b000, 3'b000, 0, 12'h000, 0, 0);
        tbl[14] = mk("f_setptr",      0, 3'b100, 0, 0, 12'h220, 12'h300, 12'h400, 8'h00, 8'h40, 3'b100, 3'b000, 0, 12'h220, 0, 0);
        tbl[15] = mk("lock1",         0, 3'b111, 0, 1, 12'h220, 12'h301, 12'h400, 8'h00, 8'h41, 3'b010, 3'b100, 0, 12'h301, 0, 0);
        tbl[16] = mk("lock2",         0, 3'b111, 0, 1, 12'h220, 12'h302, 12'h400, 8'h00, 8'h42, 3'b010, 3'b010, 0, 12'h302, 1, 0);
        tbl[17] = mk("lock_gap",      0, 3'b101, 0, 1, 12'h220, 12'h303, 12'h400, 8'h00, 8'h43, 3'b000, 3'b010, 0, 12'h000, 1, 0);
        tbl[18] = mk("lock3",         0, 3'b111, 0, 1, 12'h220, 12'h303, 12'h400, 8'h00, 8'h44, 3'b010, 3'b000, 0, 12'h303, 1, 0);
        tbl[19] = mk("lock4",         0, 3'b111, 0, 0, 12'h220, 12'h304, 12'h400, 8'h00, 8'h45, 3'b010, 3'b010, 0, 12'h304, 1, 0);
        tbl[20] = mk("post_lock_v",   0, 3'b111, 0, 0, 12'h220, 12'h304, 12'h400, 8'h00, 8'h46, 3'b001, 3'b010, 0, 12'h400, 0, 0);
        tbl[21] = mk("post_tail",     0, 3'b000, 0, 0, 12'h220, 12'h304, 12'h400, 8'h00, 8'h47, 3'b000, 3'b001, 0, 12'h000, 0, 0);

        for (int i = 0; i < 22; i++) step(tbl[i]);

        // Lock held for 16 beats: forced release with lock_err on the 16th grant
        for (int b = 1; b <= 16; b++) begin
            step(mk($sformatf("maxlock_b%0d", b), 0, (b == 1) ? 3'b010 : 3'b111, 0, 1,
                    12'h200, 12'h500 + 12'(b), 12'h400, 8'h00, 8'(8'h60 + b),
                    3'b010, (b == 1) ? 3'b000 : 3'b010, 0, 12'h500 + 12'(b),
                    (b > 1), (b == 16)));
        end
        step(mk("maxlock_after", 0, 3'b111, 0, 0, 12'h200, 12'h300, 12'h400, 8'h00, 8'h70,
                3'b001, 3'b010, 0, 12'h400, 0, 0));

        // Reset while locked with a read grant in flight
        step(mk("rstlock_enter", 0, 3'b010, 0, 1, 12'h200, 12'h310, 12'h400, 8'h00, 8'h80,
                3'b010, 3'b001, 0, 12'h310, 0, 0));
        step(mk("rstlock_rd",    0, 3'b010, 0, 1, 12'h200, 12'h311, 12'h400, 8'h00, 8'h81,
                3'b010, 3'b010, 0, 12'h311, 1, 0));
        rst = 1'b1;
        bus.f_req = 1'b1;
        bus.v_req = 1'b1;
        #1;
        chk("rstlock_in.gnt", {29'd0, bus.f_gnt, bus.d_gnt, bus.v_gnt}, 32'd0);
        chk("rstlock_in.mem_en", {31'd0, bus.mem_en}, 32'd0);
        chk("rstlock_in.mem_we", {31'd0, bus.mem_we}, 32'd0);
        chk("rstlock_in.locked", {31'd0, bus.locked}, 32'd0);
        @(posedge clk);
        #1;
        chk("rstlock_edge.rvalid", {29'd0, bus.f_rvalid, bus.d_rvalid, bus.v_rvalid}, 32'd0);
        chk("rstlock_edge.gnt", {29'd0, bus.f_gnt, bus.d_gnt, bus.v_gnt}, 32'd0);
        chk("rstlock_edge.locked", {31'd0, bus.locked}, 32'd0);
        step(mk("rstlock_release", 0, 3'b111, 0, 0, 12'h200, 12'h300, 12'h400, 8'h00, 8'h90,
                3'b100, 3'b000, 0, 12'h200, 0, 0));
        step(mk("rstlock_tail", 0, 3'b000, 0, 0, 12'h200, 12'h300, 12'h400, 8'h00, 8'h91,
                3'b000, 3'b100, 0, 12'h000, 0, 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
